// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one combinational ALU among NUM_REQ requesters.
// Optional lock feature (a requester holds the ALU across several ops): define ALU_ARB_LOCK_EN.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]      req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [2:0]                alu_control,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      busy,
  output logic [1:0]                fsm_state
);

  localparam int IDX_W = ($clog2(NUM_REQ) < 1) ? 1 : $clog2(NUM_REQ);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_found;
  logic [IDX_W-1:0] grant_sel;
  logic             grant_found;
  logic             rr_hold;
  logic [IDX_W-1:0] rr_next;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [2:0]        sel_op;

`ifdef ALU_ARB_LOCK_EN
  logic             lock_valid;
  logic [IDX_W-1:0] lock_idx;
  assign rr_hold = lock_valid;
`else
  assign rr_hold = 1'b0;
`endif

  assign fsm_state = state;

  // Search from rr_ptr upward with wrap; the first valid index wins.
  always_comb begin
    int cand;
    cand      = 0;
    rr_winner = '0;
    rr_found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = k + int'(rr_ptr);
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && req_valid[cand[IDX_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_sel   = rr_winner;
    grant_found = rr_found;
`ifdef ALU_ARB_LOCK_EN
    if (lock_valid) begin
      grant_sel   = lock_idx;
      grant_found = req_valid[lock_idx];
    end
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && grant_found) req_ready[grant_sel] = 1'b1;
  end

  assign sel_a   = req_a[int'(grant_sel)*DATA_W +: DATA_W];
  assign sel_b   = req_b[int'(grant_sel)*DATA_W +: DATA_W];
  assign sel_op  = req_op[int'(grant_sel)*3 +: 3];
  assign rr_next = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  // The ALU operand registers double as the latched request, so they hold outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_result  <= '0;
      rsp_valid   <= '0;
      busy        <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_valid  <= 1'b0;
      lock_idx    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_control <= sel_op;
            grant_idx   <= grant_sel;
            busy        <= 1'b1;
            state       <= S_EXEC;
`ifdef ALU_ARB_LOCK_EN
            lock_valid  <= req_lock[grant_sel];
            lock_idx    <= grant_sel;
`endif
          end
        end
        S_EXEC: begin
          rsp_result <= alu_result;
          rsp_valid  <= NUM_REQ'(1) << grant_idx;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[grant_idx]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
            if (!rr_hold) rr_ptr <= rr_next;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rsp_valid));
  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (state == S_RESP && !rsp_ready[grant_idx]) |=> ($stable(rsp_valid) && $stable(rsp_result)));

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter that time-shares one combinational 32-bit ALU (3-bit alu_control: 000 ADD, 001 SUB, 010 AND, 011 OR, others ADD) among NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Sits between the multi-cycle control units (address generation, branch compare, writeback) and the single shared ALU instance.
- Drives the ALU operand/control inputs and captures its result.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); requester index width IDX_W = clog2(NUM_REQ), minimum 1.
- DATA_W, 32, operand/result width; must match the ALU.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accept, at most one bit set.
- req_a  input  NUM_REQ*DATA_W  packed operand A; requester i at bits [i*DATA_W +: DATA_W].
- req_b  input  NUM_REQ*DATA_W  packed operand B.
- req_op  input  NUM_REQ*3  packed alu_control codes.
- rsp_valid  output  NUM_REQ  one-hot response valid to the owning requester.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_result  output  DATA_W  result, shared by all requesters, qualified by rsp_valid.
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_control  output  3  to ALU alu_control.
- alu_result  input  DATA_W  from ALU result (combinational).
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Clocking and reset:
  - All state updates on rising clk.
  - Reset is sampled synchronously and overrides every other event.
- Reset values:
  - State = IDLE, rr_ptr = 0, grant_idx = 0.
  - Operand, op and result registers = 0.
  - req_ready = 0, rsp_valid = 0, rsp_result = 0, alu_a/alu_b/alu_control = 0, busy = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first set index is the winner.
  - req_ready[winner] = 1 combinationally in the same cycle; all other req_ready bits = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - On a handshake: latch req_a/req_b/req_op of the winner, set grant_idx = winner, go to EXEC.
  - No valid requests: stay in IDLE, all req_ready = 0.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_control are driven from the latched registers.
  - At the clock edge, capture alu_result into the result register and go to RESP.
  - In every state other than EXEC, ALU outputs hold their last driven values (no glitching to 0).
- RESP:
  - rsp_valid[grant_idx] = 1 and rsp_result = result register.
  - Both are held stable until rsp_ready[grant_idx] = 1.
  - On that handshake: rr_ptr = (grant_idx+1) mod NUM_REQ, go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Latency and throughput:
  - Request accepted in cycle T; rsp_valid rises in cycle T+2.
  - With zero response stall, the next acceptance is at T+3 at the earliest.
  - No new request is accepted while in EXEC or RESP (req_ready = 0).
- Arithmetic:
  - Purely pass-through; the arbiter never modifies operands or the result.
  - Op codes 100..111 are forwarded unchanged (the ALU treats them as ADD).
- Fairness:
  - Winner of one grant has the lowest priority at the next arbitration.
  - A continuously valid requester is served within NUM_REQ grants.
- Boundary cases:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Request withdrawn before acceptance: legal, no side effect.
  - All requesters valid simultaneously: served strictly in index order from rr_ptr.
  - Reset during EXEC or RESP: the operation is dropped and no response is issued; rsp_valid = 0 in the cycle after reset is sampled.
- busy = (state != IDLE).

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - Adds input req_lock [NUM_REQ], sampled together with the request handshake.
  - If req_lock[winner] = 1 at acceptance, set lock_valid and lock_idx = winner.
  - While lock_valid, IDLE arbitrates only lock_idx; other requesters get req_ready = 0 and rr_ptr is not updated.
  - Lock is released when the locked requester is accepted with req_lock = 0 (rr_ptr then advances normally after its response), or on reset.
  - lock_valid resets to 0.
- Undefined:
  - No req_lock port and no lock state; plain round-robin only.

Test Plan:
- Single op: requester 1 sends a=0x0000_0005, b=0x0000_0003, op=001, rsp_ready=1 held -> req_ready[1] at T, rsp_valid=4'b0010 with rsp_result=0x0000_0002 at T+2, next acceptance no earlier than T+3.
- Contention: all four valid continuously from reset with op=000, a=i, b=0x10 -> grant order 0,1,2,3,0; each rsp_result=0x10+i; only one rsp_valid bit ever set.
- Response stall: requester 2 op=011, a=0xF0F0_0000, b=0x0000_0F0F, rsp_ready low for 5 cycles -> rsp_valid[2] and rsp_result=0xF0F0_0F0F stable across the stall; req_ready all 0 throughout.
- Wrap and fairness: rr_ptr=3 after serving requester 2, requesters 0 and 3 valid -> requester 3 granted first, then 0.
- Reset mid-op: assert reset in EXEC -> next cycle rsp_valid=0, busy=0, alu outputs=0, rr_ptr=0; the dropped request is never answered.
- ALU_ARB_LOCK_EN: requester 0 issues 3 ops with req_lock=1,1,0 while requester 1 stays valid -> requester 0 is granted 3 times consecutively, then requester 1.
